// File: rtl/auth_pkg.sv
// Shared constants, state encoding and nonce/key helpers for CS/EV mutual authentication.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package auth_pkg;

    localparam logic [63:0] K_ENC     = 64'hDEAD_BEEF_CAFE_BABE;
    localparam logic [63:0] K_TAG     = 64'hCAFE_BABE_DEAD_BEEF;
    localparam logic [7:0]  TAG_MAGIC = 8'h5A;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Feedback taps at bits 15, 13, 12 and 10.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        CHAL,
        WAIT_RSP,
        GRANT,
        DENY
    } state_t;

    function automatic logic [15:0] lfsr_next(input logic [15:0] q);
        return {q[14:0], ^(q & LFSR_TAPS)};
    endfunction

    // Response the EV must return for a given tag/nonce pair.
    function automatic logic [63:0] expected_rsp(input logic [63:0] tag, input logic [15:0] nonce);
        return tag ^ {4{nonce}} ^ K_ENC;
    endfunction

    function automatic logic [63:0] make_key(input logic [63:0] tag, input logic [15:0] nonce);
        return tag ^ {nonce, ~nonce, nonce, ~nonce};
    endfunction

endpackage

// File: rtl/cs_session_responder_if.sv
// Bundle of USP delivery, EV challenge/response and session result signals.
// Latency: n/a (wiring only).
// Backpressure: challenge uses valid/ready; delivery and response are strobes with no backpressure.
interface cs_session_responder_if;

    logic        cs_registered;
    logic        send_to_cs;
    logic [63:0] usp_tag;
    logic        auth_pass;
    logic        chal_valid;
    logic        chal_ready;
    logic [15:0] chal_nonce;
    logic        rsp_valid;
    logic [63:0] rsp_data;
    logic        final_ack;
    logic [63:0] session_key;
    logic        deny;
    logic        busy;
    logic [2:0]  retry_cnt;

    // Responder side.
    modport slave (
        input  cs_registered, send_to_cs, usp_tag, auth_pass, chal_ready, rsp_valid, rsp_data,
        output chal_valid, chal_nonce, final_ack, session_key, deny, busy, retry_cnt
    );

    // USP/EV side.
    modport master (
        output cs_registered, send_to_cs, usp_tag, auth_pass, chal_ready, rsp_valid, rsp_data,
        input  chal_valid, chal_nonce, final_ack, session_key, deny, busy, retry_cnt
    );

endinterface

// File: rtl/nonce_lfsr16.sv
// 16-bit Fibonacci LFSR nonce source, shared by the CS and EV ends so both model nonces identically.
// Latency: q_o advances one step per enabled cycle.
// Backpressure: none; en_i simply freezes the sequence.
// Ports: clk, reset (async, active-high, loads SEED), en_i (step enable), q_o (current value).
module nonce_lfsr16
    import auth_pkg::*;
#(
    parameter logic [15:0] SEED = auth_pkg::LFSR_SEED
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en_i,
    output logic [15:0] q_o
);

    logic [15:0] q_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_q <= SEED;
        end else if (en_i) begin
            q_q <= lfsr_next(q_q);
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/cs_session_responder.sv
// CS-side responder: re-checks the USP tag, challenges the EV with an LFSR nonce, grants a key or denies.
// Latency: send_to_cs -> chal_valid 2 cycles; rsp_valid -> final_ack 2 cycles; bad tag -> deny 2 cycles.
// Backpressure: challenge held (valid/ready) until accepted or attempt timer expires; inputs outside their state are dropped.
// Ports: clk, reset (async, active-high); bus (slave modport) carrying USP delivery, EV challenge/response
//        and session results (final_ack/session_key level, deny pulse, busy, retry_cnt).
module cs_session_responder
    import auth_pkg::*;
#(
    parameter int unsigned TIMEOUT   = 16,
    parameter int unsigned MAX_RETRY = 2,
    parameter logic [15:0] LFSR_SEED = auth_pkg::LFSR_SEED
) (
    input  logic                    clk,
    input  logic                    reset,
    cs_session_responder_if.slave   bus
);

    localparam logic [7:0] TIMER_LAST  = 8'(TIMEOUT - 1);
    localparam logic [2:0] RETRY_LIMIT = 3'(MAX_RETRY);

    state_t      state_q, state_d;
    logic [63:0] tag_q, tag_d;
    logic        auth_q, auth_d;
    logic [15:0] nonce_q, nonce_d;
    logic [7:0]  timer_q, timer_d;
    logic [2:0]  retry_q, retry_d;
    logic        ack_q, ack_d;
    logic [63:0] key_q, key_d;

    logic [15:0] lfsr_q;
    logic [7:0]  chk_byte;

    nonce_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .en_i  (1'b1),
        .q_o   (lfsr_q)
    );

    assign chk_byte = tag_q[7:0] ^ K_TAG[7:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            tag_q   <= '0;
            auth_q  <= 1'b0;
            nonce_q <= '0;
            timer_q <= '0;
            retry_q <= '0;
            ack_q   <= 1'b0;
            key_q   <= '0;
        end else begin
            state_q <= state_d;
            tag_q   <= tag_d;
            auth_q  <= auth_d;
            nonce_q <= nonce_d;
            timer_q <= timer_d;
            retry_q <= retry_d;
            ack_q   <= ack_d;
            key_q   <= key_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tag_d   = tag_q;
        auth_d  = auth_q;
        nonce_d = nonce_q;
        timer_d = timer_q;
        retry_d = retry_q;
        ack_d   = ack_q;
        key_d   = key_q;

        case (state_q)
            IDLE: begin
                if (bus.send_to_cs && bus.cs_registered) begin
                    tag_d   = bus.usp_tag;
                    auth_d  = bus.auth_pass;
                    ack_d   = 1'b0;
                    key_d   = '0;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if ((chk_byte == TAG_MAGIC) && auth_q) begin
                    nonce_d = lfsr_q;
                    retry_d = '0;
                    timer_d = '0;
                    state_d = CHAL;
                end else begin
                    state_d = DENY;
                end
            end
            CHAL, WAIT_RSP: begin
                // The attempt timer spans both states and is not reset by the challenge transfer.
                timer_d = timer_q + 8'd1;
                if (state_q == CHAL && bus.chal_ready) begin
                    state_d = WAIT_RSP;
                end else if (state_q == WAIT_RSP && bus.rsp_valid) begin
                    state_d = (bus.rsp_data == expected_rsp(tag_q, nonce_q)) ? GRANT : DENY;
                end else if (timer_q >= TIMER_LAST) begin
                    // >= so a handshake on the last cycle cannot push the timer past the limit and stall.
                    if (retry_q < RETRY_LIMIT) begin
                        retry_d = retry_q + 3'd1;
                        nonce_d = lfsr_q;
                        timer_d = '0;
                        state_d = CHAL;
                    end else begin
                        state_d = DENY;
                    end
                end
            end
            GRANT: begin
                ack_d   = 1'b1;
                key_d   = make_key(tag_q, nonce_q);
                state_d = IDLE;
            end
            DENY: begin
                ack_d   = 1'b0;
                key_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.chal_valid  = (state_q == CHAL);
    assign bus.chal_nonce  = nonce_q;
    assign bus.final_ack   = ack_q;
    assign bus.session_key = key_q;
    assign bus.deny        = (state_q == DENY);
    assign bus.busy        = (state_q != IDLE);
    assign bus.retry_cnt   = retry_q;

endmodule

// File: tb/tb_cs_session_responder.sv
module tb_cs_session_responder;

    localparam int          TO       = 16;
    localparam int          MR       = 2;
    localparam logic [63:0] TB_K_ENC = 64'hDEAD_BEEF_CAFE_BABE;
    localparam logic [63:0] TB_K_TAG = 64'hCAFE_BABE_DEAD_BEEF;
    localparam logic [63:0] GOOD_TAG = 64'h0123_4567_89AB_CDB5;
    localparam logic [63:0] BAD_TAG  = 64'h0123_4567_89AB_00B4;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    int checks = 0;
    int errors = 0;

    cs_session_responder_if bus();

    cs_session_responder #(
        .TIMEOUT   (TO),
        .MAX_RETRY (MR),
        .LFSR_SEED (16'hACE1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    function automatic logic [15:0] step16(input logic [15:0] v);
        logic fb;
        fb = v[15] ^ v[13] ^ v[12] ^ v[10];
        return {v[14:0], fb};
    endfunction

    logic [15:0] m_lfsr  = 16'hACE1;
    logic [15:0] m_nonce = '0;
    logic [63:0] m_tag   = '0;
    logic [63:0] m_key   = '0;
    bit          m_auth  = 0;
    bit          m_ack   = 0;
    // Session progress: tag under check, challenge on offer, awaiting response, verdict (1 grant, 2 deny).
    bit          m_check = 0;
    bit          m_offer = 0;
    bit          m_await = 0;
    int          m_verdict = 0;
    int          m_elapsed = 0;
    int          m_tries   = 0;

    always @(posedge clk or posedge reset) begin : model
        bit          n_check, n_offer, n_await;
        int          n_verdict;
        logic [63:0] good;
        if (reset) begin
            m_lfsr = 16'hACE1; m_nonce = '0; m_tag = '0; m_key = '0;
            m_auth = 0; m_ack = 0; m_check = 0; m_offer = 0; m_await = 0;
            m_verdict = 0; m_elapsed = 0; m_tries = 0;
        end else begin
            n_check = 0; n_offer = 0; n_await = 0; n_verdict = 0;
            good = m_tag ^ {4{m_nonce}} ^ TB_K_ENC;
            if (m_check) begin
                if (((m_tag ^ TB_K_TAG) & 64'hFF) == 64'h5A && m_auth) begin
                    m_nonce = m_lfsr; m_tries = 0; m_elapsed = 0; n_offer = 1;
                end else begin
                    n_verdict = 2;
                end
            end else if (m_offer || m_await) begin
                if (m_offer && bus.chal_ready) begin
                    n_await = 1; m_elapsed++;
                end else if (m_await && bus.rsp_valid) begin
                    n_verdict = (bus.rsp_data == good) ? 1 : 2;
                end else if (m_elapsed >= TO - 1) begin
                    if (m_tries < MR) begin
                        m_tries++; m_nonce = m_lfsr; m_elapsed = 0; n_offer = 1;
                    end else begin
                        n_verdict = 2;
                    end
                end else begin
                    m_elapsed++; n_offer = m_offer; n_await = m_await;
                end
            end else if (m_verdict == 1) begin
                m_ack = 1; m_key = m_tag ^ {m_nonce, ~m_nonce, m_nonce, ~m_nonce};
            end else if (m_verdict == 2) begin
                m_ack = 0; m_key = '0;
            end else if (bus.send_to_cs && bus.cs_registered) begin
                m_tag = bus.usp_tag; m_auth = bus.auth_pass; m_ack = 0; m_key = '0; n_check = 1;
            end
            m_lfsr    = step16(m_lfsr);
            m_check   = n_check;
            m_offer   = n_offer;
            m_await   = n_await;
            m_verdict = n_verdict;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (!reset) begin
            check("busy",        64'(bus.busy),        64'(m_check | m_offer | m_await | (m_verdict != 0)));
            check("chal_valid",  64'(bus.chal_valid),  64'(m_offer));
            if (m_offer) check("chal_nonce", 64'(bus.chal_nonce), 64'(m_nonce));
            check("deny",        64'(bus.deny),        64'(m_verdict == 2));
            check("final_ack",   64'(bus.final_ack),   64'(m_ack));
            check("session_key", bus.session_key,      m_key);
            check("retry_cnt",   64'(bus.retry_cnt),   64'(m_tries));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_tag(input logic [63:0] t, input logic ap);
        bus.usp_tag    = t;
        bus.auth_pass  = ap;
        bus.send_to_cs = 1'b1;
        tick();
        bus.send_to_cs = 1'b0;
    endtask

    task automatic wait_await(input string name);
        int n;
        n = 0;
        while (!m_await && n < 60) begin
            tick();
            n++;
        end
        check(name, 64'(m_await), 64'd1);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_chal_valid"}, 64'(bus.chal_valid), 64'd0);
        check({name, "_chal_nonce"}, 64'(bus.chal_nonce), 64'd0);
        check({name, "_final_ack"},  64'(bus.final_ack),  64'd0);
        check({name, "_key"},        bus.session_key,     64'd0);
        check({name, "_deny"},       64'(bus.deny),       64'd0);
        check({name, "_busy"},       64'(bus.busy),       64'd0);
        check({name, "_retry"},      64'(bus.retry_cnt),  64'd0);
        check({name, "_lfsr"},       64'(dut.u_lfsr.q_o), 64'h0000_0000_0000_ACE1);
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [63:0] tag, good;
        logic [15:0] n;
        int          offer_cyc[$];
        logic [15:0] offer_non[$];
        int          deny_at;

        bus.cs_registered = 0; bus.send_to_cs = 0; bus.usp_tag = '0; bus.auth_pass = 0;
        bus.chal_ready = 0; bus.rsp_valid = 0; bus.rsp_data = '0;

        // Pin the model's LFSR step against hand-computed values.
        check("lfsr_step1", 64'(step16(16'hACE1)), 64'h59C3);
        check("lfsr_step2", 64'(step16(step16(16'hACE1))), 64'hB387);

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1;
        reset = 0;

        // Happy path.
        bus.cs_registered = 1; bus.chal_ready = 1;
        send_tag(GOOD_TAG, 1'b1);
        tick();
        @(negedge clk);
        check("happy_chal_valid", 64'(bus.chal_valid), 64'd1);
        n = m_nonce;
        check("happy_nonce", 64'(bus.chal_nonce), 64'(n));
        tick();
        wait_await("happy_wait");
        bus.rsp_data  = GOOD_TAG ^ {4{n}} ^ TB_K_ENC;
        bus.rsp_valid = 1;
        tick();
        bus.rsp_valid = 0;
        tick();
        @(negedge clk);
        check("happy_ack",  64'(bus.final_ack), 64'd1);
        check("happy_key",  bus.session_key, GOOD_TAG ^ {n, ~n, n, ~n});
        check("happy_deny", 64'(bus.deny), 64'd0);
        tick();

        // Bad tag: deny two cycles after delivery, no challenge.
        send_tag(BAD_TAG, 1'b1);
        tick();
        @(negedge clk);
        check("badtag_deny",  64'(bus.deny), 64'd1);
        check("badtag_chal",  64'(bus.chal_valid), 64'd0);
        check("badtag_ack",   64'(bus.final_ack), 64'd0);
        tick();

        // Wrong response.
        send_tag(GOOD_TAG, 1'b1);
        wait_await("wrong_wait");
        bus.rsp_data  = (GOOD_TAG ^ {4{m_nonce}} ^ TB_K_ENC) ^ 64'h1;
        bus.rsp_valid = 1;
        tick();
        bus.rsp_valid = 0;
        @(negedge clk);
        check("wrong_deny",  64'(bus.deny), 64'd1);
        check("wrong_retry", 64'(bus.retry_cnt), 64'd0);
        check("wrong_ack",   64'(bus.final_ack), 64'd0);
        tick();

        // Timeout exhaustion: three offers 16 cycles apart, then deny.
        send_tag(GOOD_TAG, 1'b1);
        deny_at = -1;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (bus.chal_valid) begin
                offer_cyc.push_back(i);
                offer_non.push_back(bus.chal_nonce);
            end
            if (bus.deny && deny_at < 0) deny_at = i;
        end
        check("to_offers", 64'(offer_cyc.size()), 64'd3);
        if (offer_cyc.size() == 3) begin
            check("to_gap1", 64'(offer_cyc[1] - offer_cyc[0]), 64'd16);
            check("to_gap2", 64'(offer_cyc[2] - offer_cyc[1]), 64'd16);
            check("to_distinct", 64'(offer_non[0] != offer_non[1] && offer_non[1] != offer_non[2]
                                     && offer_non[0] != offer_non[2]), 64'd1);
            check("to_deny_at", 64'(deny_at), 64'(offer_cyc[0] + 48));
        end
        check("to_retry", 64'(bus.retry_cnt), 64'd2);
        tick();

        // Correct response on the timeout cycle wins.
        send_tag(GOOD_TAG, 1'b1);
        wait_await("simul_wait");
        for (int i = 0; i < 20 && m_elapsed != TO - 1; i++) tick();
        check("simul_at_limit", 64'(m_elapsed), 64'(TO - 1));
        bus.rsp_data  = GOOD_TAG ^ {4{m_nonce}} ^ TB_K_ENC;
        bus.rsp_valid = 1;
        tick();
        bus.rsp_valid = 0;
        tick();
        @(negedge clk);
        check("simul_ack",   64'(bus.final_ack), 64'd1);
        check("simul_retry", 64'(bus.retry_cnt), 64'd0);
        tick();

        // Unregistered CS: delivery ignored.
        bus.cs_registered = 0;
        send_tag(GOOD_TAG, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("unreg_busy", 64'(bus.busy), 64'd0);
        end
        tick();
        bus.cs_registered = 1;

        // Reset in WAIT_RSP aborts to idle with the LFSR reseeded.
        send_tag(GOOD_TAG, 1'b1);
        wait_await("rst_wait");
        #2 reset = 1;
        @(negedge clk);
        check_all_zero("midrst");
        tick();
        reset = 0;
        send_tag(GOOD_TAG, 1'b1);
        wait_await("post_rst_wait");
        bus.rsp_data  = GOOD_TAG ^ {4{m_nonce}} ^ TB_K_ENC;
        bus.rsp_valid = 1;
        tick();
        bus.rsp_valid = 0;
        tick();
        @(negedge clk);
        check("post_rst_ack", 64'(bus.final_ack), 64'd1);
        tick();

        // Randomized traffic checked every cycle by the model.
        for (int i = 0; i < 4000; i++) begin
            bus.send_to_cs    = ($urandom_range(0, 19) == 0);
            bus.cs_registered = ($urandom_range(0, 9) != 0);
            tag = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 1) tag[7:0] = 8'hB5;
            bus.usp_tag    = tag;
            bus.auth_pass  = ($urandom_range(0, 9) != 0);
            bus.chal_ready = ($urandom_range(0, 3) == 0);
            bus.rsp_valid  = ($urandom_range(0, 11) == 0);
            good = m_tag ^ {4{m_nonce}} ^ TB_K_ENC;
            bus.rsp_data   = ($urandom_range(0, 3) != 0) ? good : (good ^ {32'h0, $urandom | 32'h1});
            tick();
        end
        bus.send_to_cs = 0; bus.rsp_valid = 0;
        repeat (4) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
